disp_vramctrl: RTL and testbench

Reads one frame of pixels from VRAM over an AXI4 read channel and pushes the 64-bit beats into the display FIFO write port (`FIFOIN`/`FIFOWR`) on the `ACLK` side. A new address is issued only while the FIFO reports room for a full burst (`BUF_WREADY`). It is the producer that feeds the display buffer; the buffer drains pixels on `DCLK`.

---
 rtl/disp_pkg.sv | 19 +
 rtl/disp_vramctrl.sv | 139 +++++++++++++
 tb/tb_disp_vramctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the display VRAM read path: FSM encoding,
// fixed AXI read attributes and the default frame geometry.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ADDR = 2'd2,
        ST_READ = 2'd3
    } state_t;

    localparam logic [2:0] ARSIZE_8B  = 3'b011;
    localparam logic [1:0] BURST_INCR = 2'b01;

    localparam int DEF_H_PIXELS  = 640;
    localparam int DEF_V_LINES   = 480;
    localparam int DEF_BURST_LEN = 16;

endpackage

// File: rtl/disp_vramctrl.sv
// Frame reader: walks one frame of VRAM in fixed-length AXI4 INCR bursts and
// forwards every read beat, one cycle later, into the display FIFO write port.
module disp_vramctrl
    import disp_pkg::*;
#(
    parameter int H_PIXELS  = DEF_H_PIXELS,
    parameter int V_LINES   = DEF_V_LINES,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic        ACLK,
    input  logic        ARSTN,
    input  logic        DISPON,
    input  logic [31:0] DISPADDR,
    input  logic        FRAME_START,
    input  logic        BUF_WREADY,
    output logic [31:0] ARADDR,
    output logic        ARVALID,
    input  logic        ARREADY,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    input  logic [63:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RLAST,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [63:0] FIFOIN,
    output logic        FIFOWR,
    output logic        BUSY,
    output logic        RD_ERR,
    output state_t      DBG_STATE
);

    localparam int NBURST = H_PIXELS * V_LINES / 2 / BURST_LEN;
    localparam int CNT_W  = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [31:0]       ADDR_STEP  = 32'(BURST_LEN * 8);
    localparam logic [CNT_W-1:0]  LAST_BURST = CNT_W'(NBURST - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    burst_q, burst_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [31:0]         araddr_q, araddr_d;
    logic [63:0]         fifoin_q, fifoin_d;
    logic                fifowr_q, fifowr_d;
    logic                rd_err_q, rd_err_d;
    logic                r_hs, beat_last, beat_err;

    // Handshakes: a transfer occurs on each ACLK edge where VALID and READY are
    // both high; ARVALID, once raised, holds ARADDR stable until ARREADY.
    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        beat_d   = beat_q;
        araddr_d = araddr_q;
        fifoin_d = fifoin_q;
        fifowr_d = 1'b0;
        rd_err_d = rd_err_q;

        r_hs      = (state_q == ST_READ) && RVALID;
        // Whichever comes first, RLAST or the nominal final beat, closes the burst.
        beat_last = RLAST || (beat_q == LAST_BEAT);
        beat_err  = (RRESP != 2'b00) || (RLAST != (beat_q == LAST_BEAT));

        case (state_q)
            ST_IDLE: begin
                if (FRAME_START && DISPON) begin
                    state_d  = ST_WAIT;
                    araddr_d = {DISPADDR[31:7], 7'b0};
                    burst_d  = '0;
                    beat_d   = '0;
                end
            end
            ST_WAIT: begin
                if (BUF_WREADY) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (ARREADY) state_d = ST_READ;
            end
            ST_READ: begin
                if (r_hs) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_last) begin
                        beat_d = '0;
                        if ((burst_q == LAST_BURST) || !DISPON) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d  = ST_WAIT;
                            burst_d  = burst_q + 1'b1;
                            araddr_d = araddr_q + ADDR_STEP;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (r_hs) begin
            fifowr_d = 1'b1;
            fifoin_d = RDATA;
            if (beat_err) rd_err_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            state_q  <= ST_IDLE;
            burst_q  <= '0;
            beat_q   <= '0;
            araddr_q <= '0;
            fifoin_q <= '0;
            fifowr_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            burst_q  <= burst_d;
            beat_q   <= beat_d;
            araddr_q <= araddr_d;
            fifoin_q <= fifoin_d;
            fifowr_q <= fifowr_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign ARADDR    = araddr_q;
    assign ARVALID   = (state_q == ST_ADDR);
    assign ARLEN     = 8'(BURST_LEN - 1);
    assign ARSIZE    = ARSIZE_8B;
    assign ARBURST   = BURST_INCR;
    assign RREADY    = (state_q == ST_READ);
    assign FIFOIN    = fifoin_q;
    assign FIFOWR    = fifowr_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign RD_ERR    = rd_err_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_disp_vramctrl.sv
// Bench for disp_vramctrl on a reduced 64x16 frame (32 bursts of 16 beats)
// with a behavioural AXI read slave and a FIFO-write scoreboard.
`timescale 1ns/1ps
module tb_disp_vramctrl;
    import disp_pkg::*;

    localparam int H  = 64;
    localparam int V  = 16;
    localparam int BL = 16;
    localparam int NB = H * V / 2 / BL;

    logic        ACLK = 1'b0;
    logic        ARSTN;
    logic        DISPON, FRAME_START, BUF_WREADY;
    logic [31:0] DISPADDR;
    logic [31:0] ARADDR;
    logic        ARVALID, ARREADY;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST, RVALID, RREADY;
    logic [63:0] FIFOIN;
    logic        FIFOWR, BUSY, RD_ERR;
    state_t      DBG_STATE;

    always #5 ACLK = ~ACLK;

    disp_vramctrl #(.H_PIXELS(H), .V_LINES(V), .BURST_LEN(BL)) dut (
        .ACLK(ACLK), .ARSTN(ARSTN), .DISPON(DISPON), .DISPADDR(DISPADDR),
        .FRAME_START(FRAME_START), .BUF_WREADY(BUF_WREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .FIFOIN(FIFOIN),
        .FIFOWR(FIFOWR), .BUSY(BUSY), .RD_ERR(RD_ERR), .DBG_STATE(DBG_STATE)
    );

    // Knobs and frame context written by the main sequence only.
    int          ar_delay = 0;
    bit          rgap = 1'b0;
    int          err_burst = -1, err_beat = -1, early_burst = -1, nolast_burst = -1;
    bit          forbid_ar = 1'b0;
    logic [31:0] frame_base = 32'h0;
    int          frame_ar0 = 0, f_wr0 = 0, f_rd0 = 0, f_st0 = 0;

    // Monitor / scoreboard state, written by the monitor only.
    logic [63:0] exp_q[$];
    logic [63:0] exp_d;
    int          ar_count = 0, wr_count = 0, rd_count = 0, mon_beat = 0;
    int          data_bad = 0, addr_bad = 0, hold_bad = 0, forbid_bad = 0, err_drop = 0;
    int          stall_sum = 0;
    logic [31:0] last_ar_addr = 32'h0, prev_araddr = 32'h0;
    bit          prev_stall = 1'b0, rd_err_prev = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // AXI read slave: ARREADY after ar_delay stall cycles, one burst at a time.
    initial begin
        int s_beat, s_wait, s_idx;
        bit s_active, ar_hs, r_hs;
        ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; RRESP = 2'b00;
        s_beat = 0; s_wait = 0; s_idx = 0; s_active = 1'b0;
        forever begin
            @(negedge ACLK);
            ar_hs = ARVALID && ARREADY;
            r_hs  = RVALID && RREADY;
            if (ar_hs) s_idx = int'((ARADDR - frame_base) >> 7);
            @(posedge ACLK);
            #1;
            if (!ARSTN) begin
                ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
                s_active = 1'b0; s_beat = 0; s_wait = 0;
                continue;
            end
            if (ar_hs) begin
                ARREADY = 1'b0; s_active = 1'b1; s_beat = 0; s_wait = 0;
            end else if (ARVALID && !ARREADY) begin
                if (s_wait >= ar_delay) ARREADY = 1'b1;
                else s_wait++;
            end
            if (r_hs) begin
                if (RLAST || s_beat == BL - 1) s_active = 1'b0;
                s_beat++;
                RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
            end
            if (s_active && !RVALID && !(rgap && $urandom_range(0, 2) == 0)) begin
                RVALID = 1'b1;
                RDATA  = {$urandom, $urandom};
                RRESP  = (s_idx == err_burst && s_beat == err_beat) ? 2'b10 : 2'b00;
                if (s_idx == early_burst)       RLAST = (s_beat == 12);
                else if (s_idx == nolast_burst) RLAST = 1'b0;
                else                            RLAST = (s_beat == BL - 1);
            end
        end
    end

    // Monitor: FIFO writes against the R-beat queue, AR address model, AR hold rules.
    always @(negedge ACLK) begin
        if (!ARSTN) begin
            exp_q.delete();
            prev_stall  = 1'b0;
            rd_err_prev = 1'b0;
        end else begin
            if (FIFOWR) begin
                wr_count++;
                if (exp_q.size() == 0) data_bad++;
                else begin
                    exp_d = exp_q.pop_front();
                    if (FIFOIN !== exp_d) data_bad++;
                end
            end
            if (RVALID && RREADY) begin
                exp_q.push_back(RDATA);
                rd_count++;
                mon_beat++;
            end
            if (prev_stall && (!ARVALID || ARADDR !== prev_araddr)) hold_bad++;
            if (ARVALID) begin
                if (forbid_ar) forbid_bad++;
                if (ARREADY) begin
                    if (ARADDR !== frame_base + 32'((ar_count - frame_ar0) * 128)) addr_bad++;
                    last_ar_addr = ARADDR;
                    ar_count++;
                    mon_beat = 0;
                end else begin
                    stall_sum++;
                end
            end
            prev_stall  = ARVALID && !ARREADY;
            prev_araddr = ARADDR;
            if (rd_err_prev && !RD_ERR) err_drop++;
            rd_err_prev = RD_ERR;
        end
    end

    task automatic apply_reset();
        @(posedge ACLK); #1;
        ARSTN = 1'b0; DISPON = 1'b0; FRAME_START = 1'b0; BUF_WREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        #1 ARSTN = 1'b1;
    endtask

    task automatic start_frame(input logic [31:0] base);
        @(posedge ACLK); #1;
        DISPADDR = base; frame_base = {base[31:7], 7'b0};
        frame_ar0 = ar_count; f_wr0 = wr_count; f_rd0 = rd_count; f_st0 = stall_sum;
        DISPON = 1'b1; FRAME_START = 1'b1;
        @(posedge ACLK); #1;
        FRAME_START = 1'b0;
    endtask

    task automatic wait_ar(input int n, input int beat, input string what);
        int k;
        for (k = 0; k < 5000; k++) begin
            @(posedge ACLK);
            if ((ar_count - frame_ar0) == n && (beat < 0 || mon_beat == beat)) break;
        end
        check({what, " reached"}, 64'(k < 5000), 64'd1);
        #1;
    endtask

    task automatic wait_idle(input string what);
        int k;
        for (k = 0; k < 6000; k++) begin
            @(negedge ACLK);
            if (!BUSY) break;
        end
        check({what, " idle"}, 64'(k < 6000), 64'd1);
        repeat (3) @(posedge ACLK);
        #1;
    endtask

    typedef struct {
        bit          fs;
        bit          bufw;
        state_t      st;
        bit          arvalid;
        bit          rready;
        bit          busy;
        logic [31:0] araddr;
    } cyc_vec_t;

    typedef struct {
        logic [31:0] base;
        int          delay;
        bit          gap;
        int          exp_ar;
        int          exp_wr;
        logic [31:0] exp_last;
    } frame_vec_t;

    initial begin
        cyc_vec_t   cyc_tbl[7];
        frame_vec_t frm_tbl[3];
        int         k;

        cyc_tbl[0] = '{1'b1, 1'b1, ST_IDLE, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
        cyc_tbl[1] = '{1'b0, 1'b1, ST_WAIT, 1'b0, 1'b0, 1'b1, 32'h0000_4000};
        cyc_tbl[2] = '{1'b0, 1'b1, ST_ADDR, 1'b1, 1'b0, 1'b1, 32'h0000_4000};
        cyc_tbl[3] = '{1'b1, 1'b1, ST_ADDR, 1'b1, 1'b0, 1'b1, 32'h0000_4000};
        cyc_tbl[4] = '{1'b0, 1'b1, ST_ADDR, 1'b1, 1'b0, 1'b1, 32'h0000_4000};
        cyc_tbl[5] = '{1'b0, 1'b1, ST_ADDR, 1'b1, 1'b0, 1'b1, 32'h0000_4000};
        cyc_tbl[6] = '{1'b0, 1'b1, ST_READ, 1'b0, 1'b1, 1'b1, 32'h0000_4000};

        frm_tbl[0] = '{32'h2000_0000, 0, 1'b0, NB, NB * BL, 32'h2000_0F80};
        frm_tbl[1] = '{32'h1234_56FF, 7, 1'b1, NB, NB * BL, 32'h1234_6600};
        frm_tbl[2] = '{32'hFFFF_FF00, 2, 1'b1, NB, NB * BL, 32'h0000_0E80};

        ARSTN = 1'b0; DISPON = 1'b0; FRAME_START = 1'b0; BUF_WREADY = 1'b1;
        DISPADDR = 32'h0;
        repeat (4) @(posedge ACLK);
        @(negedge ACLK);
        check("rst ARVALID", 64'(ARVALID), 64'd0);
        check("rst ARADDR",  64'(ARADDR),  64'd0);
        check("rst RREADY",  64'(RREADY),  64'd0);
        check("rst FIFOWR",  64'(FIFOWR),  64'd0);
        check("rst FIFOIN",  FIFOIN,       64'd0);
        check("rst BUSY",    64'(BUSY),    64'd0);
        check("rst RD_ERR",  64'(RD_ERR),  64'd0);
        check("rst state",   64'(DBG_STATE), 64'(ST_IDLE));
        check("ARLEN",   64'(ARLEN),   64'(BL - 1));
        check("ARSIZE",  64'(ARSIZE),  64'd3);
        check("ARBURST", 64'(ARBURST), 64'd1);
        @(posedge ACLK); #1 ARSTN = 1'b1;

        // Cycle-exact start of a frame, with ARREADY held off for 3 cycles.
        ar_delay = 3; DISPON = 1'b1; DISPADDR = 32'h0000_4000;
        frame_base = 32'h0000_4000; frame_ar0 = ar_count;
        for (int i = 0; i < 7; i++) begin
            @(posedge ACLK); #1;
            FRAME_START = cyc_tbl[i].fs;
            BUF_WREADY  = cyc_tbl[i].bufw;
            @(negedge ACLK);
            check($sformatf("cyc%0d state", i),   64'(DBG_STATE), 64'(cyc_tbl[i].st));
            check($sformatf("cyc%0d ARVALID", i), 64'(ARVALID),   64'(cyc_tbl[i].arvalid));
            check($sformatf("cyc%0d RREADY", i),  64'(RREADY),    64'(cyc_tbl[i].rready));
            check($sformatf("cyc%0d BUSY", i),    64'(BUSY),      64'(cyc_tbl[i].busy));
            check($sformatf("cyc%0d ARADDR", i),  64'(ARADDR),    64'(cyc_tbl[i].araddr));
        end
        @(posedge ACLK); #1 FRAME_START = 1'b0;
        wait_idle("startup frame");
        check("startup AR count", 64'(ar_count - frame_ar0), 64'(NB));

        // Whole frames over a table of base addresses, AR stalls and R gaps.
        for (int i = 0; i < 3; i++) begin
            ar_delay = frm_tbl[i].delay; rgap = frm_tbl[i].gap;
            start_frame(frm_tbl[i].base);
            wait_idle($sformatf("frame%0d", i));
            check($sformatf("frame%0d AR count", i), 64'(ar_count - frame_ar0), 64'(frm_tbl[i].exp_ar));
            check($sformatf("frame%0d writes", i),   64'(wr_count - f_wr0),     64'(frm_tbl[i].exp_wr));
            check($sformatf("frame%0d beats", i),    64'(rd_count - f_rd0),     64'(frm_tbl[i].exp_wr));
            check($sformatf("frame%0d last addr", i), 64'(last_ar_addr),        64'(frm_tbl[i].exp_last));
            check($sformatf("frame%0d stall cycles", i), 64'(stall_sum - f_st0),
                  64'(frm_tbl[i].exp_ar * frm_tbl[i].delay));
            check($sformatf("frame%0d queue empty", i), 64'(exp_q.size()), 64'd0);
            check($sformatf("frame%0d data bad", i), 64'(data_bad), 64'd0);
            check($sformatf("frame%0d addr bad", i), 64'(addr_bad), 64'd0);
            check($sformatf("frame%0d hold bad", i), 64'(hold_bad), 64'd0);
        end
        ar_delay = 0; rgap = 1'b0;

        // BUF_WREADY withheld for 50 cycles once burst 3 is under way.
        start_frame(32'h3000_0000);
        wait_ar(4, -1, "gap burst3 AR");
        BUF_WREADY = 1'b0; forbid_ar = 1'b1;
        for (k = 0; k < 100; k++) begin
            @(negedge ACLK);
            if (DBG_STATE == ST_WAIT) break;
        end
        check("gap reached WAIT", 64'(k < 100), 64'd1);
        repeat (50) @(negedge ACLK);
        check("gap still WAIT", 64'(DBG_STATE), 64'(ST_WAIT));
        check("gap no AR", 64'(forbid_bad), 64'd0);
        @(posedge ACLK); #1;
        BUF_WREADY = 1'b1; forbid_ar = 1'b0;
        @(negedge ACLK);
        check("gap ARVALID same cycle", 64'(ARVALID), 64'd0);
        @(negedge ACLK);
        check("gap ARVALID next cycle", 64'(ARVALID), 64'd1);
        check("gap burst4 addr", 64'(ARADDR), 64'h3000_0200);
        wait_idle("gap frame");
        check("gap AR count", 64'(ar_count - frame_ar0), 64'(NB));

        // DISPON dropped at beat 5 of burst 10 with random R gaps.
        rgap = 1'b1;
        start_frame(32'h0800_0000);
        wait_ar(11, 5, "dispon beat5");
        DISPON = 1'b0;
        wait_idle("dispon frame");
        check("dispon AR count", 64'(ar_count - frame_ar0), 64'd11);
        check("dispon writes", 64'(wr_count - f_wr0), 64'(11 * BL));
        forbid_ar = 1'b1;
        repeat (30) @(negedge ACLK);
        check("dispon no AR after", 64'(forbid_bad), 64'd0);
        check("dispon data bad", 64'(data_bad), 64'd0);
        @(posedge ACLK); #1;
        forbid_ar = 1'b0; rgap = 1'b0; DISPON = 1'b1;

        // Error beats: bad RRESP, early RLAST, missing RLAST.
        apply_reset();
        check("err RD_ERR clear", 64'(RD_ERR), 64'd0);
        err_burst = 2; err_beat = 3; early_burst = 5; nolast_burst = 7;
        start_frame(32'h4000_0000);
        wait_ar(2, -1, "err burst1 AR");
        check("err RD_ERR before", 64'(RD_ERR), 64'd0);
        wait_ar(4, -1, "err burst3 AR");
        check("err RD_ERR set", 64'(RD_ERR), 64'd1);
        wait_idle("err frame");
        check("err AR count", 64'(ar_count - frame_ar0), 64'(NB));
        check("err writes", 64'(wr_count - f_wr0), 64'(NB * BL - 3));
        check("err RD_ERR held", 64'(RD_ERR), 64'd1);
        check("err no drop", 64'(err_drop), 64'd0);
        check("err data bad", 64'(data_bad), 64'd0);
        check("err addr bad", 64'(addr_bad), 64'd0);
        err_burst = -1; err_beat = -1; early_burst = -1; nolast_burst = -1;

        // FRAME_START mid-frame is ignored; then reset mid-burst.
        apply_reset();
        start_frame(32'h5000_0000);
        wait_ar(3, -1, "restart burst2 AR");
        DISPADDR = 32'h6000_0000; FRAME_START = 1'b1;
        @(posedge ACLK); #1 FRAME_START = 1'b0;
        wait_ar(6, 6, "reset point");
        check("restart ignored", 64'(addr_bad), 64'd0);
        #2 ARSTN = 1'b0;
        #1;
        check("mid rst ARVALID", 64'(ARVALID), 64'd0);
        check("mid rst ARADDR",  64'(ARADDR),  64'd0);
        check("mid rst RREADY",  64'(RREADY),  64'd0);
        check("mid rst FIFOWR",  64'(FIFOWR),  64'd0);
        check("mid rst FIFOIN",  FIFOIN,       64'd0);
        check("mid rst BUSY",    64'(BUSY),    64'd0);
        check("mid rst RD_ERR",  64'(RD_ERR),  64'd0);
        check("mid rst state",   64'(DBG_STATE), 64'(ST_IDLE));
        repeat (3) @(posedge ACLK);
        #1 ARSTN = 1'b1;
        repeat (2) @(negedge ACLK);
        check("post rst BUSY", 64'(BUSY), 64'd0);

        start_frame(32'h7000_0000);
        wait_idle("recovery frame");
        check("recovery AR count", 64'(ar_count - frame_ar0), 64'(NB));
        check("recovery writes", 64'(wr_count - f_wr0), 64'(NB * BL));
        check("recovery data bad", 64'(data_bad), 64'd0);
        check("recovery hold bad", 64'(hold_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
